// File: rtl/processor12_pkg.sv
// Shared definitions for the 12-bit processor's peripherals: register offsets,
// interrupt source limit, controller state encoding and a priority helper.
package processor12_pkg;

  localparam int IRQ_MAX_SRC = 12;

  localparam logic [2:0] OFF_PEND    = 3'd0;
  localparam logic [2:0] OFF_MASK    = 3'd1;
  localparam logic [2:0] OFF_EDGE    = 3'd2;
  localparam logic [2:0] OFF_CUR     = 3'd3;
  localparam logic [2:0] OFF_EOI     = 3'd4;
  localparam logic [2:0] OFF_VBASE_L = 3'd5;
  localparam logic [2:0] OFF_VBASE_H = 3'd6;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } irq_state_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] lowest_index(input logic [IRQ_MAX_SRC-1:0] v);
    lowest_index = '0;
    for (int i = IRQ_MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = 4'(i);
    end
  endfunction

endpackage

// File: rtl/interrupt_controller12_irq_sync.sv
// Per-source two-flop synchroniser with an edge-history flop; reports the
// synchronised level and a one-cycle rising-edge strobe.
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic hist;

  // NOTE: flops use non-blocking assignments so every stage samples the
  // previous value of its neighbour, giving a true three-stage shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= src;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;

endmodule

// File: rtl/interrupt_controller12.sv
// Memory-mapped interrupt controller: pending/mask/edge registers, lowest-index
// priority selection, in-service tracking until EOI and a registered read port.
module interrupt_controller12
  import processor12_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter logic [23:0] BASE_ADDR = 24'o77777770
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic [23:0]        address,
  input  logic [11:0]        wr_data,
  input  logic               mem_write,
  output logic [11:0]        rd_data,
  output logic               rd_hit,
  output logic [23:0]        irq
);

  localparam logic [12:0] ONE13 = 13'd1;
  localparam logic [11:0] VALID = 12'((ONE13 << NUM_SRC) - ONE13);

  logic [11:0] lvl;
  logic [11:0] rise;

  for (genvar i = 0; i < IRQ_MAX_SRC; i++) begin : g_src
    if (i < NUM_SRC) begin : g_used
      irq_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .src   (src[i]),
        .level (lvl[i]),
        .rise  (rise[i])
      );
    end else begin : g_unused
      assign lvl[i]  = 1'b0;
      assign rise[i] = 1'b0;
    end
  end

  irq_state_t  state;
  logic [11:0] pend;
  logic [11:0] mask;
  logic [11:0] edge_mode;
  logic [11:0] vbase_l;
  logic [11:0] vbase_h;
  logic [3:0]  cur_idx;

  logic        in_window;
  logic [2:0]  off;
  logic        wr_en;
  logic [11:0] cand;
  logic        take_req;
  logic [3:0]  win;
  logic [11:0] w1c;
  logic [11:0] take_bit;
  logic [11:0] pend_next;
  logic [11:0] rd_next;

  assign in_window = (address[23:3] == BASE_ADDR[23:3]);
  assign off       = address[2:0];
  assign wr_en     = mem_write & in_window;
  assign cand      = pend & mask;
  assign take_req  = (state == IDLE) && (cand != '0);
  assign win       = lowest_index(cand);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    w1c      = '0;
    take_bit = '0;
    if (wr_en && off == OFF_PEND) w1c = wr_data & VALID;
    if (take_req) take_bit = 12'(12'd1 << win);
    // A rising edge beats both the W1C write and the take into service.
    pend_next = ((((pend & ~w1c & ~take_bit) | rise) & edge_mode) |
                 (lvl & ~edge_mode)) & VALID;
  end

  always_comb begin
    rd_next = '0;
    if (in_window) begin
      case (off)
        OFF_PEND:    rd_next = pend;
        OFF_MASK:    rd_next = mask;
        OFF_EDGE:    rd_next = edge_mode;
        OFF_CUR:     rd_next = {state == ACTIVE, 7'd0, cur_idx};
        OFF_VBASE_L: rd_next = vbase_l;
        OFF_VBASE_H: rd_next = vbase_h;
        default:     rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pend      <= '0;
      mask      <= '0;
      edge_mode <= '0;
      vbase_l   <= '0;
      vbase_h   <= '0;
      cur_idx   <= '0;
      rd_data   <= '0;
      rd_hit    <= 1'b0;
    end else begin
      pend    <= pend_next;
      rd_data <= rd_next;
      rd_hit  <= in_window;

      case (state)
        IDLE: begin
          if (take_req) begin
            state   <= ACTIVE;
            cur_idx <= win;
          end
        end
        ACTIVE: begin
          if (wr_en && off == OFF_EOI) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (wr_en) begin
        case (off)
          OFF_MASK:    mask      <= wr_data & VALID;
          OFF_EDGE:    edge_mode <= wr_data & VALID;
          OFF_VBASE_L: vbase_l   <= wr_data;
          OFF_VBASE_H: vbase_h   <= wr_data;
          default:     ;
        endcase
      end
    end
  end

  // Derived only from registers, so an asynchronous reset clears it at once.
  assign irq = (state == ACTIVE) ? ({vbase_h, vbase_l} + {18'd0, cur_idx, 2'b00}) : 24'd0;

endmodule
